// File: rtl/scm65_fifo_ctrl.sv
// rtl/scm65_fifo_ctrl.sv - flow-controlled queue around one 16x16 SCM with a 2-entry output skid buffer
module scm65_fifo_ctrl #(
    parameter int DW    = 16,
    parameter int AW    = 4,
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [DW-1:0] IN_DATA,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] OUT_DATA,
    output logic          SCM_WE,
    output logic [AW-1:0] SCM_WADDR,
    output logic [DW-1:0] SCM_DIN,
    output logic          SCM_RE,
    output logic [AW-1:0] SCM_RADDR,
    input  logic [DW-1:0] SCM_DOUT,
    output logic [CW-1:0] COUNT,
    output logic          FULL,
    output logic          EMPTY
);
    localparam int MW = AW + 1;

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [MW-1:0] mem_cnt_q, mem_cnt_d;
    logic          rd_inflight_q, rd_inflight_d;
    logic [DW-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]    buf_cnt_q, buf_cnt_d, buf_cnt_p;
    logic          push, pop, re;
    logic [2:0]    occ;

    assign IN_READY  = RSTN & (mem_cnt_q < MW'(DEPTH));
    assign push      = IN_VALID & IN_READY;
    assign OUT_VALID = (buf_cnt_q != 2'd0);
    assign OUT_DATA  = buf0_q;
    assign pop       = OUT_VALID & OUT_READY;

    // Issue a read only if its word is guaranteed a buffer slot when it lands.
    assign occ = {1'b0, buf_cnt_q} + {2'b00, rd_inflight_q};
    assign re  = (mem_cnt_q != '0) && (occ < (3'd2 + {2'b00, pop}));

    assign SCM_WE    = push;
    assign SCM_WADDR = wptr_q;
    assign SCM_DIN   = IN_DATA;
    assign SCM_RE    = re;
    assign SCM_RADDR = rptr_q;

    assign COUNT = CW'(mem_cnt_q) + CW'(rd_inflight_q) + CW'(buf_cnt_q);
    assign FULL  = (mem_cnt_q == MW'(DEPTH));
    assign EMPTY = (COUNT == '0);

    always_comb begin
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        mem_cnt_d     = mem_cnt_q + MW'(push) - MW'(re);
        rd_inflight_d = re;
        buf0_d        = buf0_q;
        buf1_d        = buf1_q;
        buf_cnt_p     = buf_cnt_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (re)   rptr_d = rptr_q + AW'(1);
        if (pop) begin
            buf0_d    = buf1_q;
            buf_cnt_p = buf_cnt_q - 2'd1;
        end
        buf_cnt_d = buf_cnt_p;
        // Returning read data fills the first slot left free after this cycle's pop.
        if (rd_inflight_q) begin
            if (buf_cnt_p == 2'd0) buf0_d = SCM_DOUT;
            else                   buf1_d = SCM_DOUT;
            buf_cnt_d = buf_cnt_p + 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            mem_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
            buf0_q        <= '0;
            buf1_q        <= '0;
            buf_cnt_q     <= 2'd0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            mem_cnt_q     <= mem_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            buf0_q        <= buf0_d;
            buf1_q        <= buf1_d;
            buf_cnt_q     <= buf_cnt_d;
        end
    end
endmodule

// File: tb/tb_scm65_fifo_ctrl.sv
// tb/tb_scm65_fifo_ctrl.sv - directed table and sequence bench for scm65_fifo_ctrl with an SCM model
module tb_scm65_fifo_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data, out_data;
    logic        scm_we, scm_re;
    logic [3:0]  scm_waddr, scm_raddr;
    logic [15:0] scm_din, scm_dout;
    logic [4:0]  count;
    logic        full, empty;

    always #5 clk = ~clk;

    scm65_fifo_ctrl dut (
        .CLK(clk), .RSTN(rst_n),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
        .SCM_WE(scm_we), .SCM_WADDR(scm_waddr), .SCM_DIN(scm_din),
        .SCM_RE(scm_re), .SCM_RADDR(scm_raddr), .SCM_DOUT(scm_dout),
        .COUNT(count), .FULL(full), .EMPTY(empty)
    );

    logic [15:0] mem [16];
    always @(posedge clk) begin
        if (scm_we) mem[scm_waddr] <= scm_din;
        if (scm_re) scm_dout <= mem[scm_raddr];
        else        scm_dout <= 16'hDEAD;
    end

    int          n_tot = 0;
    int          n_bad = 0;
    logic [15:0] sb[$];
    logic [3:0]  m_wptr, m_rptr;
    logic        stall_prev;
    logic [15:0] stall_data;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clr_model();
        sb.delete();
        m_wptr = '0;
        m_rptr = '0;
        stall_prev = 1'b0;
        stall_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clr_model();
    endtask

    task automatic cyc(input logic iv, input logic [15:0] d, input logic ordy);
        logic [15:0] exp_d;
        @(negedge clk);
        in_valid = iv;
        in_data = d;
        out_ready = ordy;
        #1;
        chk("count_model", count, sb.size());
        if (stall_prev) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, stall_data);
        end
        if (scm_we) begin
            chk("waddr", scm_waddr, m_wptr);
            m_wptr = m_wptr + 4'd1;
        end
        if (scm_re) begin
            chk("raddr", scm_raddr, m_rptr);
            m_rptr = m_rptr + 4'd1;
        end
        if (in_valid && in_ready) sb.push_back(in_data);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("stale_word", out_data, -1);
            else begin
                exp_d = sb.pop_front();
                chk("out_order", out_data, exp_d);
            end
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
    endtask

    typedef struct {
        logic        iv;
        logic [15:0] din;
        logic        ordy;
        logic        we;
        logic [3:0]  wa;
        logic        re;
        logic [3:0]  ra;
        logic        ov;
        logic [15:0] od;
        logic [4:0]  cnt;
        logic        emp;
        logic        ir;
    } vec_t;

    vec_t vt[11];

    initial begin
        //        iv  din       ordy we wa  re ra  ov od        cnt emp ir
        vt[0]  = '{1, 16'hA5A5, 1,   1, 0,  0, 0,  0, 16'h0000, 0,  1,  1};
        vt[1]  = '{0, 16'h0000, 1,   0, 1,  1, 0,  0, 16'h0000, 1,  0,  1};
        vt[2]  = '{0, 16'h0000, 1,   0, 1,  0, 1,  0, 16'h0000, 1,  0,  1};
        vt[3]  = '{0, 16'h0000, 1,   0, 1,  0, 1,  1, 16'hA5A5, 1,  0,  1};
        vt[4]  = '{0, 16'h0000, 1,   0, 1,  0, 1,  0, 16'h0000, 0,  1,  1};
        vt[5]  = '{1, 16'hB0B0, 0,   1, 1,  0, 1,  0, 16'h0000, 0,  1,  1};
        vt[6]  = '{0, 16'h0000, 0,   0, 2,  1, 1,  0, 16'h0000, 1,  0,  1};
        vt[7]  = '{0, 16'h0000, 0,   0, 2,  0, 2,  0, 16'h0000, 1,  0,  1};
        vt[8]  = '{0, 16'h0000, 0,   0, 2,  0, 2,  1, 16'hB0B0, 1,  0,  1};
        vt[9]  = '{0, 16'h0000, 1,   0, 2,  0, 2,  1, 16'hB0B0, 1,  0,  1};
        vt[10] = '{0, 16'h0000, 1,   0, 2,  0, 2,  0, 16'h0000, 0,  1,  1};

        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h5555;
        out_ready = 1'b1;
        clr_model();
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we", scm_we, 0);
        chk("rst_re", scm_re, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);

        do_reset();
        for (int i = 0; i < 11; i++) begin
            cyc(vt[i].iv, vt[i].din, vt[i].ordy);
            chk("t_we", scm_we, vt[i].we);
            chk("t_waddr", scm_waddr, vt[i].wa);
            chk("t_re", scm_re, vt[i].re);
            chk("t_raddr", scm_raddr, vt[i].ra);
            chk("t_out_valid", out_valid, vt[i].ov);
            if (vt[i].ov) chk("t_out_data", out_data, vt[i].od);
            chk("t_count", count, vt[i].cnt);
            chk("t_empty", empty, vt[i].emp);
            chk("t_full", full, 0);
            chk("t_in_ready", in_ready, vt[i].ir);
        end

        // fill with 20 offered words, 18 fit
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 16'(i), 1'b0);
            chk("fill_in_ready", in_ready, (i < 18) ? 1 : 0);
        end
        repeat (2) cyc(1'b0, 16'h0, 1'b0);
        chk("fill_count", count, 18);
        chk("fill_full", full, 1);
        chk("fill_in_ready_lo", in_ready, 0);
        for (int k = 0; k < 18; k++) begin
            cyc(1'b0, 16'h0, 1'b1);
            chk("drain_valid", out_valid, 1);
        end
        cyc(1'b0, 16'h0, 1'b1);
        chk("drain_empty", empty, 1);

        // continuous streaming, pointers wrap twice
        do_reset();
        for (int i = 0; i < 45; i++) begin
            cyc(i < 40, 16'(16'h1000 + i), 1'b1);
            if (i >= 3 && i < 43) chk("stream_no_bubble", out_valid, 1);
            chk("stream_mem_le1", (count <= 5'd3) ? 1 : 0, 1);
            chk("stream_not_full", full, 0);
        end
        chk("stream_empty", empty, 1);

        // full, then pop with push offered, then push+pop
        do_reset();
        for (int i = 0; i < 18; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b0);
        repeat (2) cyc(1'b0, 16'h0, 1'b0);
        cyc(1'b1, 16'h0200, 1'b1);
        chk("fp_in_ready_lo", in_ready, 0);
        chk("fp_re", scm_re, 1);
        chk("fp_full", full, 1);
        cyc(1'b1, 16'h0201, 1'b1);
        chk("fp_in_ready_hi", in_ready, 1);
        chk("fp_count_a", count, 17);
        cyc(1'b1, 16'h0202, 1'b1);
        chk("fp_count_b", count, 17);
        for (int k = 0; k < 25; k++) cyc(1'b0, 16'h0, 1'b1);
        chk("fp_empty", empty, 1);

        // OUT_READY toggling while streaming
        do_reset();
        for (int i = 0; i < 30; i++) cyc(i < 20, 16'(16'h0300 + i), (i % 2) == 0);
        for (int k = 0; k < 20; k++) cyc(1'b0, 16'h0, 1'b1);
        chk("tog_empty", empty, 1);

        // async reset mid-stream with a read in flight
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h0400 + i), 1'b0);
        repeat (2) cyc(1'b0, 16'h0, 1'b0);
        cyc(1'b0, 16'h0, 1'b1);
        cyc(1'b0, 16'h0, 1'b0);
        chk("mid_count7", count, 7);
        chk("mid_re_before", scm_re, 0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_out_data", out_data, 0);
        chk("ar_in_ready", in_ready, 0);
        chk("ar_we", scm_we, 0);
        chk("ar_re", scm_re, 0);
        chk("ar_count", count, 0);
        chk("ar_empty", empty, 1);
        chk("ar_full", full, 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clr_model();
        cyc(1'b1, 16'h1234, 1'b1);
        chk("post_in_ready", in_ready, 1);
        chk("post_we", scm_we, 1);
        chk("post_waddr", scm_waddr, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0, 16'h0, 1'b1);
            chk("post_latency", out_valid, (k == 3) ? 1 : 0);
            if (k == 3) chk("post_data", out_data, 16'h1234);
        end
        chk("post_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
